// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port integer register file. It provides
//            NUM_RD combinational read ports with write-through bypass, two
//            prioritised write ports (port 1 wins on an address collision),
//            a per-register pending-write scoreboard and a sequenced
//            bulk-clear engine.
// Ports    : clk, reset                 - clock, async active-high reset
//            rd_addr/rd_data/rd_pending - packed read ports (port k in slice k)
//            we0/waddr0/wdata0          - write port 0
//            we1/waddr1/wdata1          - write port 1 (higher priority)
//            sb_set/sb_addr             - mark a register as pending
//            clr_req/clr_busy/clr_done  - bulk clear request / status
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    logic idle;
    logic w0_ok;
    logic w1_ok;
    logic sb_ok;

    // Writes and scoreboard sets are only accepted in IDLE; with a hardwired
    // zero register anything aimed at address 0 is dropped here, so the rest
    // of the logic never has to special-case it on the write side.
    always_comb begin
        idle  = (state == ST_IDLE);
        w0_ok = idle && we0    && !(ZERO_EN && (waddr0  == '0));
        w1_ok = idle && we1    && !(ZERO_EN && (waddr1  == '0));
        sb_ok = idle && sb_set && !(ZERO_EN && (sb_addr == '0));
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                clr_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx <= '0;
        end else if (idle && clr_req) begin
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage: port 1 is written after port 0 so it wins a collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            regs[clr_idx] <= '0;
        end else begin
            if (w0_ok) begin
                regs[waddr0] <= wdata0;
            end
            if (w1_ok) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: a set beats a same-cycle write because the set belongs
    // to a newer producer than the one whose result is being written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (state == ST_CLEAR) begin
            pending[clr_idx] <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_ok && (sb_addr == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if ((w0_ok && (waddr0 == ADDR_W'(i))) ||
                             (w1_ok && (waddr1 == ADDR_W'(i)))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. w0_ok/w1_ok already include the IDLE qualification, so
    // bypass is automatically disabled while clearing.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              pend;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs[addr];
            pend = pending[addr];
            if (ZERO_EN && (addr == '0)) begin
                data = '0;
                pend = 1'b0;
            end else if (w1_ok && (waddr1 == addr)) begin
                data = wdata1;
                pend = 1'b0;
            end else if (w0_ok && (waddr0 == addr)) begin
                data = wdata0;
                pend = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_pending[k]               = pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp against an array-based
//            reference model of the register file, scoreboard and clear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_pending;
    logic              we0, we1, sb_set, clr_req;
    logic [AW-1:0]     waddr0, waddr1, sb_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic              clr_busy, clr_done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain arrays plus a mode (0 idle, 1 clearing, 2 done)
    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];
    int            m_mode;
    int            m_pos;

    regfile_mp #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    function automatic void model_zero();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_mode = 0;
        m_pos  = 0;
    endfunction

    // Applies the rules for one rising edge using the currently driven inputs.
    function automatic void model_edge();
        if (reset) begin
            model_zero();
            return;
        end
        case (m_mode)
            0: begin
                if (we0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
                if (we1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
                if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
                if (clr_req) begin m_mode = 1; m_pos = 0; end
            end
            1: begin
                m_regs[m_pos] = '0;
                m_pend[m_pos] = 1'b0;
                if (m_pos == NR - 1) m_mode = 2;
                else m_pos++;
            end
            default: m_mode = 0;
        endcase
    endfunction

    function automatic void m_read(input int a, output logic [DW-1:0] d, output logic p);
        if (a == 0) begin
            d = '0; p = 1'b0;
        end else if (m_mode == 0 && we1 && int'(waddr1) == a) begin
            d = wdata1; p = 1'b0;
        end else if (m_mode == 0 && we0 && int'(waddr0) == a) begin
            d = wdata0; p = 1'b0;
        end else begin
            d = m_regs[a]; p = m_pend[a];
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; sb_set = 0; clr_req = 0;
        waddr0 = '0; waddr1 = '0; sb_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        rd_addr = '0;
        model_zero();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int a = 0; a < NR; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #1;
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (rd_data[k*DW +: DW] !== '0 || rd_pending[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_read port%0d addr=%0d: got data=%h pend=%b, expected 0/0",
                             k, a, rd_data[k*DW +: DW], rd_pending[k]);
                end
            end
        end
        vectors++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b done=%b, expected 0/0", clr_busy, clr_done);
        end
    endtask

    task automatic test_bypass();
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        rd_addr = {AW'(5), AW'(5)};
        #1;
        vectors++;
        if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_pending[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h pend=%b, expected deadbeef pend=0", rd_data[DW-1:0], rd_pending[0]);
        end
        tick();
        we0 = 0;
        #1;
        vectors++;
        if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_data[2*DW-1:DW] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_held: got p0=%h p1=%h, expected deadbeef", rd_data[DW-1:0], rd_data[2*DW-1:DW]);
        end
    endtask

    task automatic test_priority();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
        rd_addr = {AW'(7), AW'(7)};
        #1;
        vectors++;
        if (rd_data[DW-1:0] !== 32'h22) begin
            miscompares++;
            $display("FAIL priority_bypass: got %h, expected 00000022", rd_data[DW-1:0]);
        end
        tick();
        we0 = 0; we1 = 0;
        #1;
        vectors++;
        if (rd_data[DW-1:0] !== 32'h22) begin
            miscompares++;
            $display("FAIL priority_stored: got %h, expected 00000022", rd_data[DW-1:0]);
        end
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFF;
        rd_addr = {AW'(0), AW'(0)};
        #1;
        vectors++;
        if (rd_data[DW-1:0] !== '0) begin
            miscompares++;
            $display("FAIL zero_reg_bypass: got %h, expected 0", rd_data[DW-1:0]);
        end
        tick();
        we0 = 0;
        #1;
        vectors++;
        if (rd_data[DW-1:0] !== '0 || rd_pending[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_reg_stored: got %h pend=%b, expected 0/0", rd_data[DW-1:0], rd_pending[0]);
        end
    endtask

    task automatic test_scoreboard();
        sb_set = 1; sb_addr = 5'd3;
        tick();
        sb_set = 0;
        rd_addr = {AW'(0), AW'(3)};
        #1;
        vectors++;
        if (rd_pending[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_set: got pend=%b, expected 1", rd_pending[0]);
        end
        we1 = 1; waddr1 = 5'd3; wdata1 = 32'h1234;
        #1;
        vectors++;
        if (rd_pending[0] !== 1'b0 || rd_data[DW-1:0] !== 32'h1234) begin
            miscompares++;
            $display("FAIL sb_write_bypass: got data=%h pend=%b, expected 00001234 pend=0", rd_data[DW-1:0], rd_pending[0]);
        end
        tick();
        we1 = 0;
        #1;
        vectors++;
        if (rd_pending[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_cleared: got pend=%b, expected 0", rd_pending[0]);
        end
        sb_set = 1; sb_addr = 5'd9;
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'hAB;
        tick();
        sb_set = 0; we0 = 0;
        rd_addr = {AW'(9), AW'(0)};
        #1;
        vectors++;
        if (rd_pending[1] !== 1'b1 || rd_data[2*DW-1:DW] !== 32'hAB) begin
            miscompares++;
            $display("FAIL sb_set_wins: got data=%h pend=%b, expected 000000ab pend=1", rd_data[2*DW-1:DW], rd_pending[1]);
        end
    endtask

    task automatic test_clear();
        logic [DW-1:0] ed;
        logic          ep;
        int            busy_cnt = 0;
        int            done_cnt = 0;
        for (int a = 1; a < NR; a++) begin
            we0 = 1; waddr0 = AW'(a); wdata0 = 32'h01010101 * a;
            sb_set = a[0]; sb_addr = AW'(a);
            tick();
        end
        we0 = 0; sb_set = 0;
        // clear request together with a write: the write still commits
        clr_req = 1; we1 = 1; waddr1 = 5'd2; wdata1 = 32'h77;
        tick();
        clr_req = 0; we1 = 0;
        for (int i = 0; i < 40; i++) begin
            we0 = (i == 5); waddr0 = 5'd4; wdata0 = 32'h5555;
            sb_set = (i == 6); sb_addr = 5'd20;
            clr_req = (i == 7);
            rd_addr = {AW'($urandom_range(0, NR - 1)), AW'(4)};
            #1;
            for (int k = 0; k < NRD; k++) begin
                m_read(int'(rd_addr[k*AW +: AW]), ed, ep);
                vectors++;
                if (rd_data[k*DW +: DW] !== ed || rd_pending[k] !== ep) begin
                    miscompares++;
                    $display("FAIL clear_read cyc%0d port%0d: got data=%h pend=%b, expected data=%h pend=%b",
                             i, k, rd_data[k*DW +: DW], rd_pending[k], ed, ep);
                end
            end
            busy_cnt += int'(clr_busy);
            done_cnt += int'(clr_done);
            tick();
        end
        we0 = 0; sb_set = 0; clr_req = 0;
        vectors++;
        if (busy_cnt != NR || done_cnt != 1) begin
            miscompares++;
            $display("FAIL clear_timing: got busy_cycles=%0d done_pulses=%0d, expected %0d and 1", busy_cnt, done_cnt, NR);
        end
        for (int a = 0; a < NR; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #1;
            vectors++;
            if (rd_data[DW-1:0] !== '0 || rd_pending[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_result addr=%0d: got data=%h pend=%b, expected 0/0", a, rd_data[DW-1:0], rd_pending[0]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_cnt = 0;
        int busy_cnt = 0;
        we0 = 1; waddr0 = 5'd31; wdata0 = 32'hCAFE;
        tick();
        we0 = 0;
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        model_zero();
        rd_addr = {AW'(30), AW'(31)};
        #1;
        vectors++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0 || rd_data[DW-1:0] !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_clear: got busy=%b done=%b r31=%h, expected 0/0/0", clr_busy, clr_done, rd_data[DW-1:0]);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            done_cnt += int'(clr_done);
            busy_cnt += int'(clr_busy);
            tick();
        end
        vectors++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got done_pulses=%0d busy_cycles=%0d, expected 0/0", done_cnt, busy_cnt);
        end
        for (int a = 0; a < NR; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #1;
            vectors++;
            if (rd_data[2*DW-1:DW] !== '0 || rd_pending[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_result addr=%0d: got data=%h pend=%b, expected 0/0", a, rd_data[2*DW-1:DW], rd_pending[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          ep;
        for (int n = 0; n < 600; n++) begin
            we0     = 1'($urandom_range(0, 1));
            we1     = 1'($urandom_range(0, 1));
            sb_set  = 1'($urandom_range(0, 1));
            clr_req = ($urandom_range(0, 79) == 0);
            waddr0  = AW'($urandom_range(0, 7));
            waddr1  = AW'($urandom_range(0, 7));
            sb_addr = AW'($urandom_range(0, 7));
            wdata0  = $urandom;
            wdata1  = $urandom;
            rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, NR - 1))};
            #1;
            for (int k = 0; k < NRD; k++) begin
                m_read(int'(rd_addr[k*AW +: AW]), ed, ep);
                vectors++;
                if (rd_data[k*DW +: DW] !== ed || rd_pending[k] !== ep) begin
                    miscompares++;
                    $display("FAIL random_read n=%0d port%0d addr=%0d: got data=%h pend=%b, expected data=%h pend=%b",
                             n, k, rd_addr[k*AW +: AW], rd_data[k*DW +: DW], rd_pending[k], ed, ep);
                end
            end
            vectors++;
            if (clr_busy !== (m_mode == 1) || clr_done !== (m_mode == 2)) begin
                miscompares++;
                $display("FAIL random_status n=%0d: got busy=%b done=%b, expected busy=%b done=%b",
                         n, clr_busy, clr_done, (m_mode == 1), (m_mode == 2));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
